// File: rtl/seg_scan_arbiter.sv
// Scan controller for a 4-digit common-anode 7-segment display, shared by
// the game datapath and a one-shot message overlay. Blink gating: SEG_SCAN_BLINK_EN.
module seg_scan_arbiter #(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 25000000,
  parameter int MSG_FRAMES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] game_val,
  input  logic [3:0]  game_blank,
  input  logic [3:0]  blink_mask,
  input  logic        msg_req,
  input  logic [15:0] msg_val,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (MSG_FRAMES > 1) ? $clog2(MSG_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(MSG_FRAMES - 1);

  typedef enum logic [1:0] {
    S_GAME,
    S_PEND,
    S_MSG
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [15:0]   msg_q, msg_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [3:0]    digit_q, digit_d;
  logic [6:0]    disp_q, disp_d;

  logic          slot_wrap;
  logic          frame_end;
  logic [3:0]    blink_off;
  logic          src_msg;
  logic          blank;
  logic [3:0]    nib;

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_off = blink_mask & {4{phase_q}};
`else
  logic [3:0] unused_blink;
  assign unused_blink = blink_mask ^ 4'(BLINK_DIV % 16);
  assign blink_off    = 4'b0000;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_wrap = (slot_q == SLOT_MAX);
    frame_end = slot_wrap && (idx_q == 2'd3);
    slot_d    = slot_wrap ? '0 : slot_q + SW'(1);
    idx_d     = slot_wrap ? idx_q + 2'd1 : idx_q;
  end

  // A request accepted on a boundary cycle is still in GAME there, so
  // PEND only ever sees boundaries strictly after the accept.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    msg_d   = msg_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      S_GAME: begin
        if (msg_req) begin
          msg_d   = msg_val;
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (frame_end) begin
          frame_d = '0;
          state_d = S_MSG;
        end
      end
      S_MSG: begin
        if (frame_end) begin
          if (frame_q == FRAME_MAX) begin
            frame_d = '0;
            busy_d  = 1'b0;
            state_d = S_GAME;
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end
      default: begin
        state_d = S_GAME;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    src_msg = (state_q == S_MSG);
    nib     = src_msg ? msg_q[{idx_q, 2'b00} +: 4]
                      : game_val[{idx_q, 2'b00} +: 4];
    blank   = !src_msg &&
              (game_blank[idx_q] || blink_off[idx_q]);
    digit_d = ~(4'b0001 << idx_q);
    disp_d  = blank ? 7'b1111111 : seg7(nib);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_GAME;
      slot_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      msg_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      digit_q <= 4'b1111;
      disp_q  <= 7'b1111111;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      msg_q   <= msg_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      digit_q <= digit_d;
      disp_q  <= disp_d;
    end
  end

  assign msg_ack  = ack_q;
  assign msg_busy = busy_q;
  assign DIGIT    = digit_q;
  assign DISPLAY  = disp_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Scoreboard bench for seg_scan_arbiter: a time-arithmetic model predicts
// each cycle's registered outputs; a monitor pops and compares after every edge.
module tb_seg_scan_arbiter;

  localparam int SD = 4;
  localparam int BD = 64;
  localparam int MF = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] game_val = '0;
  logic [3:0]  game_blank = '0;
  logic [3:0]  blink_mask = '0;
  logic        msg_req = 1'b0;
  logic [15:0] msg_val = '0;
  logic        msg_ack;
  logic        msg_busy;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;

  seg_scan_arbiter #(
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD),
    .MSG_FRAMES(MF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .game_val  (game_val),
    .game_blank(game_blank),
    .blink_mask(blink_mask),
    .msg_req   (msg_req),
    .msg_val   (msg_val),
    .msg_ack   (msg_ack),
    .msg_busy  (msg_busy),
    .DIGIT     (DIGIT),
    .DISPLAY   (DISPLAY)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] disp;
    logic       ack;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int          cyc;
  bit          have;
  int          acc, b0, bend;
  logic [15:0] mval;

  // Lit segments of each hex glyph, written as the letters a..g.
  string lits[16] = '{"abcdef", "bc", "abdeg", "abcdg",
                      "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg",
                      "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input int h);
    logic [6:0] g;
    string s;
    g = 7'h7f;
    s = lits[h];
    for (int i = 0; i < s.len(); i++) begin
      int b;
      b = int'(s[i]) - 97;
      g[b] = 1'b0;
    end
    return g;
  endfunction

  function automatic bit in_msg(input int c);
    return have && c > b0 && c <= bend;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, want);
    end
  endtask

  task automatic model_reset();
    cyc  = 0;
    have = 0;
    acc  = 0;
    b0   = 0;
    bend = 0;
    mval = '0;
  endtask

  // Drive inputs for the current cycle and predict the outputs the next edge registers.
  task automatic step(input bit req, input logic [15:0] gv,
                      input logic [3:0] gb, input logic [3:0] bm,
                      input logic [15:0] mv);
    exp_t e;
    int   k;
    bit   blank;
    bit   take;
    msg_req    = req;
    game_val   = gv;
    game_blank = gb;
    blink_mask = bm;
    msg_val    = mv;
    k     = (cyc / SD) % 4;
    e.dig = ~(4'b0001 << k);
    if (in_msg(cyc)) begin
      e.disp = glyph(int'((mval >> (4 * k)) & 16'hF));
    end else begin
      blank = gb[k];
`ifdef SEG_SCAN_BLINK_EN
      if (bm[k] && ((cyc / BD) % 2 == 1)) blank = 1;
`endif
      e.disp = blank ? 7'h7f : glyph(int'((gv >> (4 * k)) & 16'hF));
    end
    take = req && (!have || cyc > bend);
    if (take) begin
      have = 1;
      acc  = cyc;
      b0   = ((cyc + 1) / FR + 1) * FR - 1;
      bend = b0 + MF * FR;
      mval = mv;
    end
    e.ack  = take;
    e.busy = have && cyc >= acc && cyc < bend;
    q.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("DIGIT", 16'(DIGIT), 16'(e.dig));
      check("DISPLAY", 16'(DISPLAY), 16'(e.disp));
      check("msg_ack", 16'(msg_ack), 16'(e.ack));
      check("msg_busy", 16'(msg_busy), 16'(e.busy));
    end
  end

  task automatic check_reset_outs();
    check("rst_DIGIT", 16'(DIGIT), 16'h000f);
    check("rst_DISPLAY", 16'(DISPLAY), 16'h007f);
    check("rst_ack", 16'(msg_ack), 16'h0000);
    check("rst_busy", 16'(msg_busy), 16'h0000);
  endtask

  task automatic rand_step(input bit req);
    step(req, 16'($urandom), 4'($urandom) & 4'($urandom),
         4'($urandom), 16'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit held;
    model_reset();
    game_val = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs();

    @(negedge clk);
    rst = 1'b1;
    repeat (2 * FR) step(0, 16'h1234, 4'h0, 4'h0, 16'h0);
    repeat (FR) step(0, 16'h1234, 4'h8, 4'h0, 16'h0);
    repeat (BD * 2) step(0, 16'h1234, 4'h0, 4'h1, 16'h0);

    repeat (6) step(0, 16'h5678, 4'h0, 4'h0, 16'h0);
    step(1, 16'h5678, 4'h0, 4'h0, 16'hFACE);
    repeat (20) step(0, 16'h5678, 4'h0, 4'h0, 16'h0);
    step(1, 16'h5678, 4'h0, 4'h0, 16'hBEEF);
    repeat (40) step(0, 16'h5678, 4'h0, 4'h0, 16'h0);
    repeat (3 * MF * FR) step(1, 16'h9ABC, 4'h2, 4'h0, 16'h0D0E);
    repeat (FR * 3) step(0, 16'h9ABC, 4'h0, 4'h0, 16'h0);

    held = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) held = ~held;
      rand_step(held || ($urandom_range(0, 39) == 0));
    end

    n = 0;
    while (!in_msg(cyc) && n < 400) begin
      rand_step(1);
      n++;
    end
    if (!in_msg(cyc)) begin
      errors++;
      $display("FAIL msg_takeover: got no MSG window want one within 400 cycles");
    end
    repeat (7) rand_step(0);

    rst = 1'b0;
    #1;
    check_reset_outs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs();
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    repeat (3 * FR) rand_step(0);
    for (int i = 0; i < 400; i++) rand_step($urandom_range(0, 19) == 0);

    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
